fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS core. It holds the architectural PC register, issues a request/acknowledge read to instruction memory, and buffers the returned word until decode accepts it. It sits directly downstream of the next-PC logic: it drives the current PC to that logic and loads the computed next PC back into the PC register when decode takes the current instruction.

---
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, req/ack instruction memory read, one-entry hold buffer for decode.
// Optional macro FETCH_ADDR_CHECK_EN enables fetch address checking (misaligned / out-of-range -> exc_adel).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] pc,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        exc_adel
);

`ifdef FETCH_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, instr_q;
  logic        exc_q;
  logic        bad;

  // Decoded from the registered pc only, so no input reaches an output combinationally.
  assign bad = CHECK_EN && ((pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (bad || imem_ack) state_nxt = HOLD;
      HOLD:    if (instr_ready) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      exc_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == REQ) begin
        // A bad address completes locally without touching memory.
        if (bad) begin
          instr_q <= 32'h0;
          exc_q   <= 1'b1;
        end else if (imem_ack) begin
          instr_q <= imem_rdata;
          exc_q   <= 1'b0;
        end
      end
      if (state == HOLD && instr_ready) pc_q <= npc;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = (state == REQ) && !bad;
  assign instr_valid = (state == HOLD);
  assign instr       = instr_q;
  assign exc_adel    = CHECK_EN & exc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences with a scoreboard of expected fetch addresses and results.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc, npc, imem_addr, imem_rdata, instr;
  logic        imem_req, imem_ack, instr_valid, instr_ready, exc_adel;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .npc(npc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .exc_adel(exc_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_t;

  fetch_t      exp_q[$];
  logic [31:0] addr_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        req_d = 1'b0;
  logic        vld_d = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFF);
`else
    return 1'b0;
`endif
  endfunction

  // Advance to the next falling edge and score any newly started request or newly presented instruction.
  task automatic step();
    fetch_t e;
    logic [31:0] a;
    @(negedge clk);
    if (imem_req && !req_d) begin
      if (addr_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
      else begin
        a = addr_q.pop_front();
        chk("sb_addr", imem_addr, a);
      end
    end
    if (instr_valid && !vld_d) begin
      if (exp_q.size() == 0) chk("valid_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_pc", pc, e.pc);
        chk("sb_exc", {31'h0, exc_adel}, {31'h0, e.exc});
      end
    end
    req_d = imem_req;
    vld_d = instr_valid;
  endtask

  // Entered one falling edge after the DUT moved to REQ for address a.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int waits);
    if (addr_bad(a)) begin
      chk("req_suppressed", {31'h0, imem_req}, 32'd0);
      exp_q.push_back('{pc: a, instr: 32'h0, exc: 1'b1});
      step();
    end else begin
      for (int i = 0; i < waits; i++) begin
        chk("req_held", {31'h0, imem_req}, 32'd1);
        chk("addr_held", imem_addr, a);
        step();
      end
      chk("req_at_ack", {31'h0, imem_req}, 32'd1);
      imem_ack   = 1'b1;
      imem_rdata = d;
      exp_q.push_back('{pc: a, instr: d, exc: 1'b0});
      step();
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    chk("valid_after_ack", {31'h0, instr_valid}, 32'd1);
    chk("req_low_in_hold", {31'h0, imem_req}, 32'd0);
  endtask

  task automatic handshake(input logic [31:0] a);
    instr_ready = 1'b1;
    npc         = a;
    if (!addr_bad(a)) addr_q.push_back(a);
    step();
    instr_ready = 1'b0;
    npc         = $urandom;
    chk("valid_drop", {31'h0, instr_valid}, 32'd0);
  endtask

  task automatic release_seq(input logic [31:0] d);
    reset_n    = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = d;
    addr_q.push_back(RESET_PC);
    step();
    chk("first_req", {31'h0, imem_req}, 32'd1);
    fetch(RESET_PC, d, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_req"}, {31'h0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_exc"}, {31'h0, exc_adel}, 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    npc         = 32'h0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    repeat (2) step();
    chk_reset_vals("rst");

    release_seq(32'h2401_0001);

    // Decode stalls: everything frozen while npc wiggles.
    for (int i = 0; i < 5; i++) begin
      npc = $urandom;
      step();
      chk("frz_instr", instr, 32'h2401_0001);
      chk("frz_pc", pc, RESET_PC);
      chk("frz_valid", {31'h0, instr_valid}, 32'd1);
    end

    handshake(32'h0000_3010);
    chk("hs_addr", imem_addr, 32'h0000_3010);
    instr_ready = 1'b1;  // ignored in REQ, and also high on the ack edge
    npc         = 32'hDEAD_0000;
    fetch(32'h0000_3010, 32'h8C22_0004, 3);
    chk("ready_ack_pc", pc, 32'h0000_3010);

    // Reset lands mid-REQ on the same cycle as an ack.
    handshake(32'h0000_3020);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    reset_n    = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    step();
    chk("rst_no_capture", instr, 32'h0);
    release_seq(32'h2401_0001);

    handshake(32'h0000_3002);
    fetch(32'h0000_3002, 32'h0000_0020, 0);
    handshake(32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h1234_5678, 1);
    handshake(32'h0000_0000);
    fetch(32'h0000_0000, 32'hA5A5_5A5A, 0);
    handshake(32'h0000_6FFC);
    fetch(32'h0000_6FFC, 32'h0BAD_F00D, 2);

    chk("addr_q_left", addr_q.size(), 32'd0);
    chk("exp_q_left", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
